ledblink_multi: RTL and testbench

Multi-channel, run-time-programmable LED blinker, generalising the fixed 1 s / 100 ms single-LED blinker. A shared 1 ms tick prescaler drives N_CH independent channels. Each channel has its own mode, period and on-time, and an optional burst mode that emits a fixed number of flashes and then reports completion. It sits between board-level status logic and the LED pins.

---
 rtl/ledblink_multi.sv | 138 +++++++++++++
 tb/tb_ledblink_multi.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ledblink_multi.sv
// Multi-channel programmable LED blinker on a shared 1 ms tick.
// Define LEDBLINK_MULTI_BURST_EN to build burst mode (mode 11).
module ledblink_multi #(
  parameter int CLK_FREQ = 125000000,
  parameter int TICK_DIV = CLK_FREQ / 1000,
  parameter int N_CH     = 4,
  parameter int MS_W     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2*N_CH-1:0]      mode_i,
  input  logic [MS_W*N_CH-1:0]   period_ms_i,
  input  logic [MS_W*N_CH-1:0]   on_ms_i,
  input  logic [8*N_CH-1:0]      burst_i,
  output logic [N_CH-1:0]        led_o,
  output logic [N_CH-1:0]        done_o
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unused_clk_freq = CLK_FREQ;

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick  = (pre_q == PW'(TICK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) pre_q <= '0;
    else       pre_q <= pre_d;
  end

`ifndef LEDBLINK_MULTI_BURST_EN
  logic unused_burst;
  assign unused_burst = ^burst_i;
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [1:0]      mode_in, mreg_q, mreg_d;
    logic [MS_W-1:0] per_in, on_in, per_fix;
    logic [MS_W-1:0] ph_q, ph_d, per_q, per_d, on_q, on_d;
    logic            led_q, led_d, chg, wrap, frz;

    assign mode_in = mode_i[2*c +: 2];
    assign per_in  = period_ms_i[MS_W*c +: MS_W];
    assign on_in   = on_ms_i[MS_W*c +: MS_W];
    assign per_fix = (per_in == '0) ? MS_W'(1) : per_in;
    assign chg     = (mode_in != mreg_q);
    assign wrap    = tick && (ph_q == per_q - MS_W'(1));

    always_comb begin
      mreg_d = mreg_q;
      ph_d   = ph_q;
      per_d  = per_q;
      on_d   = on_q;
      led_d  = (mreg_q == 2'b01) ||
               (mreg_q[1] && !frz && (ph_q < on_q));
      if (chg) begin
        mreg_d = mode_in;
        ph_d   = '0;
        per_d  = per_fix;
        on_d   = on_in;
      end else if (!mreg_q[1]) begin
        ph_d = '0;
      end else if (!frz && wrap) begin
        // period boundary: the only point new timing is adopted
        ph_d  = '0;
        per_d = per_fix;
        on_d  = on_in;
      end else if (!frz && tick) begin
        ph_d = ph_q + MS_W'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        mreg_q <= 2'b00;
        ph_q   <= '0;
        per_q  <= MS_W'(1);
        on_q   <= '0;
        led_q  <= 1'b0;
      end else begin
        mreg_q <= mreg_d;
        ph_q   <= ph_d;
        per_q  <= per_d;
        on_q   <= on_d;
        led_q  <= led_d;
      end
    end

    assign led_o[c] = led_q;

`ifdef LEDBLINK_MULTI_BURST_EN
    logic [7:0] bc_q, bc_d;
    logic       idle_q, idle_d, done_q, done_d;

    // zero remaining flashes darkens the LED even before idle is set
    assign frz = (mreg_q == 2'b11) && (idle_q || bc_q == 8'd0);

    always_comb begin
      bc_d   = bc_q;
      idle_d = idle_q;
      done_d = 1'b0;
      if (chg) begin
        bc_d   = burst_i[8*c +: 8];
        idle_d = 1'b0;
      end else if (mreg_q == 2'b11 && !idle_q) begin
        if (bc_q == 8'd0) begin
          idle_d = 1'b1;
          done_d = 1'b1;
        end else if (wrap) begin
          bc_d = bc_q - 8'd1;
          if (bc_q == 8'd1) begin
            idle_d = 1'b1;
            done_d = 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        bc_q   <= 8'd0;
        idle_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        bc_q   <= bc_d;
        idle_q <= idle_d;
        done_q <= done_d;
      end
    end

    assign done_o[c] = done_q;
`else
    assign frz       = 1'b0;
    assign done_o[c] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_ledblink_multi.sv
// Bench for ledblink_multi: vector table, corner sequences, random vs model.
// Expectations follow LEDBLINK_MULTI_BURST_EN when it is defined.
module tb_ledblink_multi;
  localparam int TD = 4;
  localparam int NC = 2;
  localparam int W  = 16;
`ifdef LEDBLINK_MULTI_BURST_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2*NC-1:0] mode = '0;
  logic [W*NC-1:0] period = '0;
  logic [W*NC-1:0] on_ms = '0;
  logic [8*NC-1:0] bst = '0;
  logic [NC-1:0]   led_o, done_o;

  int checks = 0;
  int errors = 0;

  ledblink_multi #(
    .CLK_FREQ(4000), .TICK_DIV(TD), .N_CH(NC), .MS_W(W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode),
    .period_ms_i(period), .on_ms_i(on_ms),
    .burst_i(bst), .led_o(led_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Reference: each channel is "position within the current ms period",
  // a number of flashes still owed and a finished flag.
  int          tk = 0;
  logic [1:0]  md[NC];
  int          pos[NC], per[NC], onm[NC], left[NC];
  bit          fin[NC];
  logic [NC-1:0] e_led = '0, e_done = '0;

  function automatic void model_edge();
    bit t;
    t = (tk == TD - 1);
    for (int c = 0; c < NC; c++) begin
      logic [1:0] mi;
      int pi, oi, bi;
      bit bm, dark;
      mi   = mode[2*c +: 2];
      pi   = int'(period[W*c +: W]);
      oi   = int'(on_ms[W*c +: W]);
      bi   = int'(bst[8*c +: 8]);
      bm   = BEN && (md[c] == 2'b11);
      dark = bm && (fin[c] || left[c] == 0);
      e_led[c]  = !rst && (md[c] == 2'b01 ||
                  (md[c][1] && !dark && pos[c] < onm[c]));
      e_done[c] = 1'b0;
      if (rst) begin
        md[c] = 2'b00; pos[c] = 0; left[c] = 0; fin[c] = 0;
      end else if (mi != md[c]) begin
        md[c] = mi; pos[c] = 0;
        per[c] = (pi == 0) ? 1 : pi;
        onm[c] = oi; left[c] = bi; fin[c] = 0;
      end else if (bm && !fin[c] && left[c] == 0) begin
        fin[c] = 1; e_done[c] = 1'b1;
      end else if (md[c][1] && !dark && t) begin
        if (pos[c] + 1 == per[c]) begin
          pos[c] = 0;
          per[c] = (pi == 0) ? 1 : pi;
          onm[c] = oi;
          if (bm) begin
            left[c]--;
            if (left[c] == 0) begin
              fin[c] = 1; e_done[c] = 1'b1;
            end
          end
        end else begin
          pos[c]++;
        end
      end
    end
    tk = rst ? 0 : (tk + 1) % TD;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    checks++;
    if (led_o !== e_led || done_o !== e_done) begin
      errors++;
      $display("FAIL model t=%0t led_o=%b done_o=%b want led=%b done=%b",
               $time, led_o, done_o, e_led, e_done);
    end
  endtask

  task automatic chk(string nm, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic set_ch(int c, logic [1:0] m, int p, int o, int b);
    logic [W-1:0] pv, ov;
    logic [7:0]   bv;
    pv = W'(p); ov = W'(o); bv = 8'(b);
    mode[2*c +: 2]  = m;
    period[W*c +: W] = pv;
    on_ms[W*c +: W]  = ov;
    bst[8*c +: 8]    = bv;
  endtask

  // count ch0 high cycles and done pulses over n edges
  task automatic run_count(int n, output int hi, output int dn);
    hi = 0; dn = 0;
    for (int i = 0; i < n; i++) begin
      step();
      hi += int'(led_o[0]);
      dn += int'(done_o[0]);
    end
  endtask

  // next edge will be a tick edge
  task automatic align();
    while (tk != TD - 1) step();
  endtask

  typedef struct {
    logic [1:0] m;
    int p, o, b, win, hi, dn;
  } vec_t;

  vec_t tv[9];

  initial begin
    int h1, h2, h3, d1, d2;
    for (int c = 0; c < NC; c++) begin
      md[c] = 2'b00; pos[c] = 0; per[c] = 1;
      onm[c] = 0; left[c] = 0; fin[c] = 0;
    end

    tv[0] = '{2'b10, 5, 2, 0, 40, 16, 0};
    tv[1] = '{2'b10, 5, 7, 0, 40, 40, 0};
    tv[2] = '{2'b10, 5, 0, 0, 40, 0, 0};
    tv[3] = '{2'b10, 0, 3, 0, 40, 40, 0};
    tv[4] = '{2'b10, 0, 0, 0, 40, 0, 0};
    tv[5] = '{2'b01, 5, 2, 0, 40, 40, 0};
    tv[6] = '{2'b11, 4, 1, 3, 64, BEN ? 12 : 16, BEN ? 1 : 0};
    tv[7] = '{2'b11, 4, 1, 0, 20, BEN ? 0 : 8, BEN ? 1 : 0};
    tv[8] = '{2'b11, 3, 5, 2, 48, BEN ? 24 : 48, BEN ? 1 : 0};

    // reset with mode 01 applied on both channels
    mode = 4'b0101;
    rst  = 1'b1;
    repeat (3) begin
      step();
      chk("rst_led", int'(led_o), 0);
      chk("rst_done", int'(done_o), 0);
    end
    rst = 1'b0;
    step();
    chk("rel1_led", int'(led_o), 0);
    step();
    chk("rel2_led0", int'(led_o[0]), 1);
    mode = '0;
    repeat (3) step();

    foreach (tv[i]) begin
      set_ch(0, 2'b00, 0, 0, 0);
      repeat (3) step();
      align();
      set_ch(0, tv[i].m, tv[i].p, tv[i].o, tv[i].b);
      step();
      run_count(tv[i].win, h1, d1);
      chk($sformatf("vec%0d_high", i), h1, tv[i].hi);
      chk($sformatf("vec%0d_done", i), d1, tv[i].dn);
    end

    // on-time change mid-period waits for the wrap
    set_ch(0, 2'b00, 0, 0, 0);
    repeat (3) step();
    align();
    set_ch(0, 2'b10, 5, 2, 0);
    step();
    run_count(5, h1, d1);
    set_ch(0, 2'b10, 5, 4, 0);
    run_count(15, h2, d2);
    chk("midchg_p1", h1 + h2, 8);
    run_count(20, h3, d1);
    chk("midchg_p2", h3, 16);

    // re-entering burst from 00 runs a new burst
    set_ch(0, 2'b00, 0, 0, 0);
    repeat (3) step();
    align();
    set_ch(0, 2'b11, 4, 1, 2);
    step();
    run_count(40, h1, d1);
    chk("reburst_high", h1, BEN ? 8 : 12);
    chk("reburst_done", d1, BEN ? 1 : 0);

    // reset in the middle of a burst
    set_ch(0, 2'b00, 0, 0, 0);
    repeat (3) step();
    align();
    set_ch(0, 2'b11, 4, 1, 3);
    step();
    repeat (20) step();
    rst = 1'b1;
    step();
    chk("midrst_led", int'(led_o), 0);
    chk("midrst_done", int'(done_o), 0);
    set_ch(0, 2'b00, 0, 0, 0);
    step();
    rst = 1'b0;
    run_count(60, h1, d1);
    chk("postrst_done", d1, 0);
    chk("postrst_high", h1, 0);

    // random traffic against the model
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) step();
        rst = 1'b0;
      end else begin
        set_ch(int'($urandom_range(0, NC - 1)),
               2'($urandom_range(0, 3)),
               int'($urandom_range(0, 6)),
               int'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)));
      end
      repeat ($urandom_range(1, 40)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
